// File: rtl/helio_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : helio_menu_ctrl
// Brief    : Pushbutton debounce and menu state machine for the HelioSmart UI.
// Revision : 1.0 - initial release
// ============================================================================
module helio_menu_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int NUM_MIN    = 2,
    parameter int NUM_MAX    = 9
) (
    input  logic       CLOCK_50,
    input  logic       iRST_N,
    input  logic [3:0] iKEY,
    output logic [3:0] mensaje,
    output logic       modo_auto,
    output logic       modo_manual,
    output logic [3:0] num,
    output logic       num_ok
);

    localparam int                 c_CNT_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0]         c_NUM_MIN  = 4'(NUM_MIN);
    localparam logic [3:0]         c_NUM_MAX  = 4'(NUM_MAX);
    localparam logic [3:0]         c_MSG_MENU = 4'd0;
    localparam logic [3:0]         c_MSG_AUTO = 4'd1;
    localparam logic [3:0]         c_MSG_SEL  = 4'd2;

    logic [3:0] w_press;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        logic               r_s1, r_s2, r_deb, r_deb_d, r_arm, r_press;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_diff;

        assign w_diff = r_s2 ^ r_deb;

        // Until armed, the counter measures a continuous release so a key held
        // through reset cannot produce a press.
        always_ff @(posedge CLOCK_50) begin
            if (!iRST_N) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_deb   <= 1'b1;
                r_deb_d <= 1'b1;
                r_arm   <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= iKEY[gi];
                r_s2    <= r_s1;
                r_deb_d <= r_deb;
                r_press <= r_deb_d & ~r_deb;
                if (!r_arm) begin
                    if (!r_s2) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_arm <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end else if (!w_diff) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    // Fixed priority A > C > UP > OK; losers in the same cycle are dropped.
    logic w_ev_a, w_ev_c, w_ev_up, w_ev_ok;
    assign w_ev_a  = w_press[0];
    assign w_ev_c  = w_press[1] & ~w_press[0];
    assign w_ev_up = w_press[2] & ~|w_press[1:0];
    assign w_ev_ok = w_press[3] & ~|w_press[2:0];

    typedef enum logic [1:0] {
        S_MENU = 2'd0,
        S_AUTO = 2'd1,
        S_SEL  = 2'd2,
        S_MAN  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_mensaje, r_num;
    logic       r_auto, r_man, r_num_ok;

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            r_state   <= S_MENU;
            r_mensaje <= c_MSG_MENU;
            r_auto    <= 1'b0;
            r_man     <= 1'b0;
            r_num     <= c_NUM_MIN;
            r_num_ok  <= 1'b0;
        end else begin
            r_num_ok <= 1'b0;
            case (r_state)
                S_MENU: begin
                    if (w_ev_a) begin
                        r_state <= S_AUTO; r_mensaje <= c_MSG_AUTO; r_auto <= 1'b1;
                    end else if (w_ev_c) begin
                        r_state <= S_SEL;  r_mensaje <= c_MSG_SEL;
                    end
                end
                S_AUTO: begin
                    if (w_ev_c) begin
                        r_state <= S_SEL;  r_mensaje <= c_MSG_SEL;  r_auto <= 1'b0;
                    end else if (w_ev_ok) begin
                        r_state <= S_MENU; r_mensaje <= c_MSG_MENU; r_auto <= 1'b0;
                    end
                end
                S_SEL: begin
                    if (w_ev_a) begin
                        r_state <= S_AUTO; r_mensaje <= c_MSG_AUTO; r_auto <= 1'b1;
                    end else if (w_ev_up) begin
                        r_num <= (r_num == c_NUM_MAX) ? c_NUM_MIN : r_num + 4'd1;
                    end else if (w_ev_ok) begin
                        r_state <= S_MAN; r_man <= 1'b1; r_num_ok <= 1'b1;
                    end
                end
                S_MAN: begin
                    if (w_ev_a) begin
                        r_state <= S_AUTO; r_mensaje <= c_MSG_AUTO; r_auto <= 1'b1; r_man <= 1'b0;
                    end else if (w_ev_c) begin
                        r_state <= S_SEL;  r_man <= 1'b0;
                    end else if (w_ev_ok) begin
                        r_state <= S_MENU; r_mensaje <= c_MSG_MENU; r_man <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_MENU; r_mensaje <= c_MSG_MENU; r_auto <= 1'b0; r_man <= 1'b0;
                end
            endcase
        end
    end

    assign mensaje     = r_mensaje;
    assign modo_auto   = r_auto;
    assign modo_manual = r_man;
    assign num         = r_num;
    assign num_ok      = r_num_ok;

endmodule
`default_nettype wire

// File: tb/tb_helio_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_helio_menu_ctrl
// Brief    : Directed self-checking bench for helio_menu_ctrl (DEB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_helio_menu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] mensaje, num;
    logic       modo_auto, modo_manual, num_ok;

    int n_pass  = 0;
    int n_total = 0;

    helio_menu_ctrl #(
        .DEB_CYCLES(4),
        .NUM_MIN   (2),
        .NUM_MAX   (9)
    ) dut (
        .CLOCK_50   (clk),
        .iRST_N     (rst_n),
        .iKEY       (key),
        .mensaje    (mensaje),
        .modo_auto  (modo_auto),
        .modo_manual(modo_manual),
        .num        (num),
        .num_ok     (num_ok)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Full press: output settles 7 edges after the first low sample; then release.
    task automatic press(input int k);
        key[k] = 1'b0;
        step(8);
        key[k] = 1'b1;
        step(8);
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'hF;
        step(2);
        chk("rst_mensaje", 8'(mensaje), 8'd0);
        chk("rst_num", 8'(num), 8'd2);
        chk("rst_flags", {5'd0, modo_auto, modo_manual, num_ok}, 8'd0);
        rst_n = 1'b1;
        step(10);

        // A held: changes exactly 7 cycles after first low sample, then holds.
        key[0] = 1'b0;
        step(7);
        chk("a_before_latency", 8'(mensaje), 8'd0);
        step(1);
        chk("a_at_latency_msg", 8'(mensaje), 8'd1);
        chk("a_at_latency_auto", 8'(modo_auto), 8'd1);
        step(3);
        chk("a_held_msg", 8'(mensaje), 8'd1);
        key[0] = 1'b1;
        step(8);
        press(3);
        chk("ok_back_menu", 8'(mensaje), 8'd0);
        chk("ok_back_auto", 8'(modo_auto), 8'd0);

        // Glitch and bounce on C: no event.
        key[1] = 1'b0; step(3);
        key[1] = 1'b1; step(2);
        key[1] = 1'b0; step(2);
        key[1] = 1'b1; step(1);
        key[1] = 1'b0; step(2);
        key[1] = 1'b1; step(10);
        chk("glitch_msg", 8'(mensaje), 8'd0);

        // Select number: C, then UP x8 wraps 9 -> 2.
        press(1);
        chk("sel_msg", 8'(mensaje), 8'd2);
        chk("sel_num0", 8'(num), 8'd2);
        for (int i = 0; i < 8; i++) begin
            press(2);
            chk("up_num", 8'(num), (i == 7) ? 8'd2 : 8'(3 + i));
            chk("up_msg", 8'(mensaje), 8'd2);
        end

        // Reach num=5, confirm with OK and look at the pulse cycle.
        press(2); press(2); press(2);
        chk("num5", 8'(num), 8'd5);
        key[3] = 1'b0;
        step(7);
        chk("ok_pre_pulse", {6'd0, num_ok, modo_manual}, 8'd0);
        step(1);
        chk("ok_pulse", {num_ok, modo_manual, 2'd0, num}, 8'hC5);
        step(1);
        chk("ok_pulse_end", {num_ok, modo_manual, 2'd0, num}, 8'h45);
        key[3] = 1'b1;
        step(8);
        press(2);
        chk("man_up_frozen", 8'(num), 8'd5);
        press(3);
        chk("man_ok_menu", {2'd0, modo_manual, 1'b0, mensaje}, 8'h00);

        // A and UP debounced together in S_SEL: A wins, num unchanged.
        press(1);
        key = 4'b1010;
        step(8);
        key = 4'hF;
        step(8);
        chk("prio_msg", 8'(mensaje), 8'd1);
        chk("prio_auto", 8'(modo_auto), 8'd1);
        chk("prio_num", 8'(num), 8'd5);

        // Into S_MAN with num=7, then reset while A is mid-debounce.
        press(1); press(2); press(2); press(3);
        chk("man7", {2'd0, modo_manual, 1'b0, num}, 8'h27);
        key[0] = 1'b0;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("rst_mid_msg", 8'(mensaje), 8'd0);
        chk("rst_mid_num", 8'(num), 8'd2);
        chk("rst_mid_flags", {5'd0, modo_auto, modo_manual, num_ok}, 8'd0);
        step(20);
        chk("held_no_event", {3'd0, modo_auto, mensaje}, 8'h00);
        key[0] = 1'b1;
        step(10);
        chk("release_no_event", 8'(mensaje), 8'd0);
        press(0);
        chk("repress_msg", 8'(mensaje), 8'd1);
        chk("repress_auto", 8'(modo_auto), 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
